seq_chunk_adder: RTL

- Multi-cycle, parametrised adder/subtractor that processes operands CHUNK bits per clock over WIDTH/CHUNK cycles.
- Successor to the combinational ripple-carry adder chain: it trades latency for a short carry path, and adds a subtract mode and a start/busy/done handshake.
- Serves datapaths where wide operands (64 bits and up) must not sit on a single combinational carry chain.

---
 rtl/seq_chunk_adder.sv | 112 +++++++++++
 1 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock over WIDTH/CHUNK cycles, LSB chunk first.
// Optional Z/V flag outputs are enabled by defining SEQ_CHUNK_ADDER_FLAGS_EN.
module seq_chunk_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
  ,
  output logic             Z,
  output logic             V
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] next_work;
  logic             carry;
  logic [CHUNK:0]   chunk_sum;
  logic             last;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Operands shift right so the active chunk always sits at bit 0; results
  // enter at the top, so after N steps chunk i lands at position i.
  always_comb begin
    chunk_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry};
    next_work = (work >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    last      = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      work  <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      Z     <= 1'b0;
      V     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B ^ {WIDTH{Sub}};
            carry <= Cin ^ Sub;
            cnt   <= '0;
            work  <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1] ^ Sub;
`endif
          end
        end
        RUN: begin
          a_reg <= a_reg >> CHUNK;
          b_reg <= b_reg >> CHUNK;
          work  <= next_work;
          carry <= chunk_sum[CHUNK];
          cnt   <= cnt + CW'(1);
          if (last) begin
            S     <= next_work;
            Cout  <= chunk_sum[CHUNK];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
            Z     <= (next_work == '0);
            V     <= (a_msb == b_msb) && (next_work[WIDTH-1] != a_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
